// File: rtl/bmp_load_sequencer_if.sv
// bmp_load_sequencer_if: UART receive byte stream and SRAM port-1 write bus
interface bmp_load_sequencer_if;
  logic        rs_rx_valid;
  logic [7:0]  rs_rx_data;
  logic        s1_WE;
  logic [17:0] s1_Addr;
  logic [31:0] s1_WD;
  modport master (input rs_rx_valid, rs_rx_data, output s1_WE, s1_Addr, s1_WD);
  modport slave (output rs_rx_valid, rs_rx_data, input s1_WE, s1_Addr, s1_WD);
endinterface

// File: rtl/bmp_load_sequencer.sv
// bmp_load_sequencer: checks a 32-bpp BMP header from UART, packs pixel pairs to RGB565 words, writes them to SRAM
module bmp_load_sequencer #(
  parameter int          WIDTH   = 640,
  parameter int          HEIGHT  = 480,
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_kick,
  output logic        load_done,
  output logic        busy,
  output logic [1:0]  err,
  output logic [17:0] last_addr,
  bmp_load_sequencer_if.master io
);
  localparam int WORDS = WIDTH * HEIGHT / 2;
  typedef enum logic [2:0] {IDLE, HDR, PIX, WR0, WR1, DONE, ERR} state_t;
  state_t      state;
  logic [1:0]  kick_sync;
  logic [5:0]  hdr_cnt;
  logic [2:0]  byte_idx;
  logic [23:0] tcnt, tcnt_next;
  logic [4:0]  b0, r0, b1, r1;
  logic [5:0]  g0, g1;
  logic [7:0]  d;
  logic        strobe, hdr_bad, tout;
  logic [31:0] packed_word;
  always_comb begin
    d           = io.rs_rx_data;
    strobe      = io.rs_rx_valid;
    hdr_bad     = (hdr_cnt == 6'd0  && d != 8'h42) || (hdr_cnt == 6'd1  && d != 8'h4d) ||
                  (hdr_cnt == 6'd10 && d != 8'h36) || (hdr_cnt == 6'd28 && d != 8'h20);
    tout        = !strobe && tcnt == TIMEOUT - 24'd1;
    tcnt_next   = strobe ? 24'd0 : tout ? tcnt : tcnt + 24'd1;
    packed_word = {g1[2:0], r1, b1, g1[5:3], g0[2:0], r0, b0, g0[5:3]};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      kick_sync  <= '0;
      hdr_cnt    <= '0;
      byte_idx   <= '0;
      tcnt       <= '0;
      {b0, g0, r0, b1, g1, r1} <= '0;
      load_done  <= 1'b0;
      busy       <= 1'b0;
      err        <= '0;
      last_addr  <= '1;
      io.s1_WE   <= 1'b1;
      io.s1_Addr <= '0;
      io.s1_WD   <= '0;
    end else begin
      kick_sync <= {kick_sync[0], load_kick};
      // assembly register keeps filling during the write cycles
      if (strobe && (state == PIX || state == WR0 || state == WR1)) begin
        byte_idx <= byte_idx + 3'd1;
        case (byte_idx)
          3'd0: b0 <= d[7:3];
          3'd1: g0 <= d[7:2];
          3'd2: r0 <= d[7:3];
          3'd4: b1 <= d[7:3];
          3'd5: g1 <= d[7:2];
          3'd6: r1 <= d[7:3];
          default: ;
        endcase
      end
      case (state)
        IDLE, DONE, ERR: if (kick_sync[1]) begin
          load_done  <= 1'b0;
          err        <= '0;
          io.s1_Addr <= '0;
          hdr_cnt    <= '0;
          byte_idx   <= '0;
          tcnt       <= '0;
          last_addr  <= '1;
          busy       <= 1'b1;
          state      <= HDR;
        end
        HDR: if (strobe) begin
          tcnt    <= '0;
          hdr_cnt <= hdr_cnt + 6'd1;
          if (hdr_bad) begin
            err[0] <= 1'b1;
            busy   <= 1'b0;
            state  <= ERR;
          end else if (hdr_cnt == 6'd53) state <= PIX;
        end else if (hdr_cnt != 6'd0) begin
          if (tout) begin
            err[1] <= 1'b1;
            busy   <= 1'b0;
            state  <= ERR;
          end else tcnt <= tcnt_next;
        end
        PIX: if (strobe) begin
          tcnt <= '0;
          if (byte_idx == 3'd7) begin
            io.s1_WD <= packed_word;
            io.s1_WE <= 1'b0;
            state    <= WR0;
          end
        end else if (tout) begin
          err[1] <= 1'b1;
          busy   <= 1'b0;
          state  <= ERR;
        end else tcnt <= tcnt_next;
        WR0: begin
          tcnt      <= tcnt_next;
          io.s1_WE  <= 1'b1;
          last_addr <= io.s1_Addr;
          state     <= WR1;
        end
        WR1: begin
          tcnt <= tcnt_next;
          if (io.s1_Addr == 18'(WORDS - 1)) begin
            load_done <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            io.s1_Addr <= io.s1_Addr + 18'd1;
            state      <= PIX;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
